neo_window_sequencer: RTL and testbench
=======================================

# neo_window_sequencer

Drives the write and read ports of the NEO sample memory, which is a registered single-port-pair RAM with 1-cycle read latency. Accepts an input sample stream, writes each sample into a circular buffer in that memory, and reads back the three-sample window (x[n-1], x[n], x[n+1]) for the downstream NEO datapath. Sits between the ADC sample source and the energy operator.

## Interface
- N, 8, sample width (signed)
- M, 16, memory depth; M ≥ 4
- Clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  N  signed input sample
- mem_waddr  out  $clog2(M)+1  memory write address, registered
- mem_wdata  out  N  memory write data, signed, registered
- mem_raddr  out  $clog2(M)+1  memory read address, combinational from state and pointer
- mem_rdata  in  N  memory read data, valid the cycle after mem_raddr is presented
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts the window
- out_prev, out_cur, out_next  out  N each  signed x[n-1], x[n], x[n+1]
- out_energy  out  2N+1  signed; present only with NEO_ENERGY_EN

## Operation
- The memory writes on every cycle except when waddr==0 and wdata==0. The sequencer therefore drives waddr=0, wdata=0 as the no-write encoding whenever it is not writing.
- Address 0 is reserved. The ring uses addresses 1..M-1. The write pointer wp resets to 1 and wraps from M-1 to 1. This lets a zero sample be stored safely.
- The fill count saturates at 3 and resets to 0.
- FSM states: IDLE, WR, RD0, RD1, RD2, RD3, OUT.
  - IDLE: in_ready=1. When in_valid is high: register mem_waddr=wp, mem_wdata=in_data, then go to WR.
  - WR: the memory commits the write. Advance wp and count. If count (after increment) < 3, go to IDLE; otherwise go to RD0.
- Let p be the address just written, and p-1 / p-2 be the ring predecessors (skipping 0).
  - RD0: raddr=p-2.
  - RD1: raddr=p-1; capture out_prev←mem_rdata.
  - RD2: raddr=p; capture out_cur.
  - RD3: capture out_next.
  - OUT: out_valid=1; outputs held stable until out_ready; then go to IDLE.
- mem_raddr=0 outside RD0–RD2. mem_waddr/mem_wdata are 0 in every cycle except WR.
- in_ready is 0 in every state except IDLE. No sample is accepted while a window is pending.

## Timing
- Reset values: in_ready=1, out_valid=0, out_prev/cur/next=0, out_energy=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, wp=1, count=0, state IDLE.
- Cycle numbering, with accept at cycle 0: WR at cycle 1, RD0 at 2, RD1 at 3, RD2 at 4, RD3 at 5, out_valid high at cycle 6.
- Minimum sample period is 7 cycles when out_ready is held high.
- Windows slide by one sample. Each accepted sample after the third produces exactly one window.
- A reset mid-operation returns the block to reset values. Stale memory contents are never read because count=0.
- in_valid during a non-IDLE state is ignored; the source must hold it.

## Configuration
- NEO_ENERGY_EN defined:
  - adds the out_energy port;
  - out_energy = out_cur*out_cur − out_prev*out_next, full precision, signed 2N+1 bits;
  - combinational from the output registers, so valid together with out_valid.
- NEO_ENERGY_EN undefined: the port and multipliers are absent; all other behaviour is identical.

## Test plan
- Reset: assert reset 2 cycles -> all outputs 0, in_ready=1, mem_waddr=mem_wdata=0.
- Fill: send 3, 5, 7 -> no out_valid after 3 or 5. Six cycles after accepting 7: out_prev=3, out_cur=5, out_next=7, out_energy=4.
- Zero and extremes: send 0, -128, 127 -> during WR of the 0 sample, mem_waddr=1 and mem_wdata=0. Window is 0,-128,127, out_energy=16384. Then send -128 -> window -128,127,-128, out_energy=16129−16384=−255.
- Wrap: send 1..17 with out_ready=1 -> sample 16 is written to address 1 and sample 17 to address 2. Window for 17 reads addresses 15,1,2 and yields 15,16,17.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> outputs stable, in_ready=0. Release -> one handshake, then IDLE.
- Reset during RD1 after 3 samples -> out_valid never asserts. The next two samples produce no window; the third produces one.

Source files
------------

// File: rtl/neo_window_sequencer_if.sv
// Sample-stream, memory-port and window-output bundle for neo_window_sequencer.
// The sequencer uses the master modport. The environment uses the slave modport:
// the sample source, the sample memory and the NEO datapath.
// If NEO_ENERGY_EN is defined, the bundle also carries out_energy.
interface neo_window_sequencer_if #(
  parameter int N = 8,
  parameter int M = 16
);
  localparam int AW = $clog2(M) + 1;

  // Input sample stream
  logic                 in_valid;
  logic                 in_ready;
  logic signed [N-1:0]  in_data;

  // Sample memory ports (registered RAM, 1-cycle read latency)
  logic [AW-1:0]        mem_waddr;
  logic signed [N-1:0]  mem_wdata;
  logic [AW-1:0]        mem_raddr;
  logic signed [N-1:0]  mem_rdata;

  // Three-sample window towards the energy operator
  logic                 out_valid;
  logic                 out_ready;
  logic signed [N-1:0]  out_prev;
  logic signed [N-1:0]  out_cur;
  logic signed [N-1:0]  out_next;
`ifdef NEO_ENERGY_EN
  logic signed [2*N:0]  out_energy;
`endif

  modport master (
    input  in_valid, in_data, mem_rdata, out_ready,
    output in_ready, mem_waddr, mem_wdata, mem_raddr,
    output out_valid, out_prev, out_cur, out_next
`ifdef NEO_ENERGY_EN
    , output out_energy
`endif
  );

  modport slave (
    output in_valid, in_data, mem_rdata, out_ready,
    input  in_ready, mem_waddr, mem_wdata, mem_raddr,
    input  out_valid, out_prev, out_cur, out_next
`ifdef NEO_ENERGY_EN
    , input out_energy
`endif
  );
endinterface

// File: rtl/neo_window_sequencer.sv
// neo_window_sequencer: writes incoming samples into a circular buffer.
// The buffer lives in the NEO sample memory.
// After each write the block reads back the window x[n-1], x[n], x[n+1].
// Address 0 is never used by the ring, so waddr=0/wdata=0 means "no write".
// Optional feature macro: NEO_ENERGY_EN adds
//   out_energy = cur*cur - prev*next.
module neo_window_sequencer #(
  parameter int N = 8,
  parameter int M = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  neo_window_sequencer_if.master bus_if
);

  localparam int AW = $clog2(M) + 1;
  localparam logic [AW-1:0] RING_FIRST = AW'(1);
  localparam logic [AW-1:0] RING_LAST  = AW'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_OUT
  } state_t;

  // Ring neighbours over addresses 1..M-1 (0 is the reserved no-write slot)
  function automatic logic [AW-1:0] ring_pred(input logic [AW-1:0] a);
    return (a == RING_FIRST) ? RING_LAST : a - RING_FIRST;
  endfunction

  function automatic logic [AW-1:0] ring_succ(input logic [AW-1:0] a);
    return (a == RING_LAST) ? RING_FIRST : a + RING_FIRST;
  endfunction

  state_t              state_q, state_d;
  logic [AW-1:0]       wp_q, wp_d;
  logic [1:0]          count_q, count_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic signed [N-1:0] wdata_q, wdata_d;
  logic signed [N-1:0] prev_q, prev_d;
  logic signed [N-1:0] cur_q, cur_d;
  logic signed [N-1:0] next_q, next_d;

  logic [AW-1:0]       raddr_c;
  logic                in_ready_c;
  logic                out_valid_c;
  logic [1:0]          count_inc;
  logic [AW-1:0]       p_addr;

  // Once WR has run, wp points past the newest sample.
  // Its predecessor is the address just written.
  assign p_addr    = ring_pred(wp_q);
  assign count_inc = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;

  // State, pointers, registered memory write port and window registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      wp_q    <= RING_FIRST;
      count_q <= 2'd0;
      waddr_q <= '0;
      wdata_q <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
    end
  end

  // Next-state logic, read-address sequencing and window capture
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    count_d     = count_q;
    waddr_d     = '0;
    wdata_d     = '0;
    prev_d      = prev_q;
    cur_d       = cur_q;
    next_d      = next_q;
    raddr_c     = '0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus_if.in_valid) begin
          waddr_d = wp_q;
          wdata_d = bus_if.in_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        // The memory commits waddr_q/wdata_q at the end of this cycle.
        wp_d    = ring_succ(wp_q);
        count_d = count_inc;
        state_d = (count_inc == 2'd3) ? S_RD0 : S_IDLE;
      end
      S_RD0: begin
        raddr_c = ring_pred(ring_pred(p_addr));
        state_d = S_RD1;
      end
      S_RD1: begin
        raddr_c = ring_pred(p_addr);
        prev_d  = bus_if.mem_rdata;
        state_d = S_RD2;
      end
      S_RD2: begin
        raddr_c = p_addr;
        cur_d   = bus_if.mem_rdata;
        state_d = S_RD3;
      end
      S_RD3: begin
        next_d  = bus_if.mem_rdata;
        state_d = S_OUT;
      end
      S_OUT: begin
        out_valid_c = 1'b1;
        if (bus_if.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_if.in_ready  = in_ready_c;
  assign bus_if.mem_waddr = waddr_q;
  assign bus_if.mem_wdata = wdata_q;
  assign bus_if.mem_raddr = raddr_c;
  assign bus_if.out_valid = out_valid_c;
  assign bus_if.out_prev  = prev_q;
  assign bus_if.out_cur   = cur_q;
  assign bus_if.out_next  = next_q;

`ifdef NEO_ENERGY_EN
  // Teager energy from the window registers.
  // Operands are widened to the result width first.
  // The true result always fits in 2N+1 signed bits, so truncating the products is exact.
  logic signed [2*N:0] prev_x, cur_x, next_x;
  logic signed [2*N:0] cur_sq, cross_prod;

  assign prev_x            = {{(N+1){prev_q[N-1]}}, prev_q};
  assign cur_x             = {{(N+1){cur_q[N-1]}}, cur_q};
  assign next_x            = {{(N+1){next_q[N-1]}}, next_q};
  assign cur_sq            = cur_x * cur_x;
  assign cross_prod        = prev_x * next_x;
  assign bus_if.out_energy = cur_sq - cross_prod;
`endif

endmodule

// File: tb/tb_neo_window_sequencer.sv
// Directed bench for neo_window_sequencer with a behavioural model of the sample memory.
module tb_neo_window_sequencer;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  neo_window_sequencer_if #(.N(8), .M(16)) bus ();

  neo_window_sequencer #(.N(8), .M(16)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memory: writes unless waddr==0 && wdata==0, registered read
  logic signed [7:0] mem_model [0:15];
  always @(posedge clk) begin
    if (!(bus.mem_waddr == 5'd0 && bus.mem_wdata == 8'sd0))
      mem_model[bus.mem_waddr[3:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem_model[bus.mem_raddr[3:0]];
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents one sample. Returns at the negedge of the WR cycle.
  task automatic push(input logic signed [7:0] d);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (!bus.in_ready) begin
      miscompares++;
      $display("FAIL push_ready_timeout sample=%0d in_ready=%0b required=1", d, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Waits up to budget cycles for out_valid.
  // Returns the cycles waited, or -1 if out_valid never rose.
  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic test_reset;
    do_reset(2);
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    vectors++;
    if ({bus.out_prev, bus.out_cur, bus.out_next} !== 24'd0) begin
      miscompares++; $display("FAIL reset_window got=%0d,%0d,%0d exp=0,0,0", bus.out_prev, bus.out_cur, bus.out_next);
    end
    vectors++;
    if (bus.mem_waddr !== 5'd0 || bus.mem_wdata !== 8'sd0 || bus.mem_raddr !== 5'd0) begin
      miscompares++; $display("FAIL reset_mem waddr=%0d wdata=%0d raddr=%0d exp=0,0,0", bus.mem_waddr, bus.mem_wdata, bus.mem_raddr);
    end
`ifdef NEO_ENERGY_EN
    vectors++;
    if (bus.out_energy !== 17'sd0) begin miscompares++; $display("FAIL reset_energy got=%0d exp=0", bus.out_energy); end
`endif
    $display("reset: checked reset state");
  endtask

  task automatic test_fill;
    int lat;
    do_reset(2);
    bus.out_ready = 1'b1;
    push(8'sd3);
    wait_valid(8, lat);
    vectors++;
    if (lat !== -1) begin miscompares++; $display("FAIL fill_no_window_3 got_lat=%0d exp=-1", lat); end
    push(8'sd5);
    wait_valid(8, lat);
    vectors++;
    if (lat !== -1) begin miscompares++; $display("FAIL fill_no_window_5 got_lat=%0d exp=-1", lat); end
    push(8'sd7);
    wait_valid(10, lat);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL fill_latency got=%0d exp=5", lat); end
    vectors++;
    if (bus.out_prev !== 8'sd3 || bus.out_cur !== 8'sd5 || bus.out_next !== 8'sd7) begin
      miscompares++; $display("FAIL fill_window got=%0d,%0d,%0d exp=3,5,7", bus.out_prev, bus.out_cur, bus.out_next);
    end
`ifdef NEO_ENERGY_EN
    vectors++;
    if (bus.out_energy !== 17'sd4) begin miscompares++; $display("FAIL fill_energy got=%0d exp=4", bus.out_energy); end
`endif
    $display("fill: window 3,5,7 latency %0d", lat);
  endtask

  task automatic test_zero_extremes;
    int lat;
    do_reset(2);
    bus.out_ready = 1'b1;
    push(8'sd0);
    vectors++;
    if (bus.mem_waddr !== 5'd1 || bus.mem_wdata !== 8'sd0) begin
      miscompares++; $display("FAIL zero_write got_addr=%0d got_data=%0d exp=1,0", bus.mem_waddr, bus.mem_wdata);
    end
    wait_valid(8, lat);
    push(-8'sd128);
    wait_valid(8, lat);
    push(8'sd127);
    wait_valid(10, lat);
    vectors++;
    if (bus.out_prev !== 8'sd0 || bus.out_cur !== -8'sd128 || bus.out_next !== 8'sd127) begin
      miscompares++; $display("FAIL extremes_window1 got=%0d,%0d,%0d exp=0,-128,127", bus.out_prev, bus.out_cur, bus.out_next);
    end
`ifdef NEO_ENERGY_EN
    vectors++;
    if (bus.out_energy !== 17'sd16384) begin miscompares++; $display("FAIL extremes_energy1 got=%0d exp=16384", bus.out_energy); end
`endif
    push(-8'sd128);
    wait_valid(10, lat);
    vectors++;
    if (bus.out_prev !== -8'sd128 || bus.out_cur !== 8'sd127 || bus.out_next !== -8'sd128) begin
      miscompares++; $display("FAIL extremes_window2 got=%0d,%0d,%0d exp=-128,127,-128", bus.out_prev, bus.out_cur, bus.out_next);
    end
`ifdef NEO_ENERGY_EN
    vectors++;
    if (bus.out_energy !== -17'sd255) begin miscompares++; $display("FAIL extremes_energy2 got=%0d exp=-255", bus.out_energy); end
`endif
    $display("zero_extremes: windows 0,-128,127 and -128,127,-128");
  endtask

  task automatic test_wrap;
    int lat;
    do_reset(2);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      push(8'(i));
      if (i == 16) begin
        vectors++;
        if (bus.mem_waddr !== 5'd1) begin miscompares++; $display("FAIL wrap_waddr16 got=%0d exp=1", bus.mem_waddr); end
      end
      if (i == 17) begin
        vectors++;
        if (bus.mem_waddr !== 5'd2) begin miscompares++; $display("FAIL wrap_waddr17 got=%0d exp=2", bus.mem_waddr); end
        @(negedge clk);
        vectors++;
        if (bus.mem_raddr !== 5'd15) begin miscompares++; $display("FAIL wrap_raddr_rd0 got=%0d exp=15", bus.mem_raddr); end
        @(negedge clk);
        vectors++;
        if (bus.mem_raddr !== 5'd1) begin miscompares++; $display("FAIL wrap_raddr_rd1 got=%0d exp=1", bus.mem_raddr); end
        @(negedge clk);
        vectors++;
        if (bus.mem_raddr !== 5'd2) begin miscompares++; $display("FAIL wrap_raddr_rd2 got=%0d exp=2", bus.mem_raddr); end
      end
      wait_valid(10, lat);
      if (i >= 3) begin
        vectors++;
        if (lat < 0 || bus.out_prev !== 8'(i - 2) || bus.out_cur !== 8'(i - 1) || bus.out_next !== 8'(i)) begin
          miscompares++;
          $display("FAIL wrap_window_%0d lat=%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", i, lat,
                   bus.out_prev, bus.out_cur, bus.out_next, i - 2, i - 1, i);
        end
        $display("wrap: sample %0d window %0d,%0d,%0d", i, bus.out_prev, bus.out_cur, bus.out_next);
      end else begin
        vectors++;
        if (lat !== -1) begin miscompares++; $display("FAIL wrap_no_window_%0d got_lat=%0d exp=-1", i, lat); end
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    do_reset(2);
    bus.out_ready = 1'b0;
    push(8'sd10);
    wait_valid(8, lat);
    push(8'sd20);
    wait_valid(8, lat);
    push(8'sd30);
    wait_valid(10, lat);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd99;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.mem_waddr !== 5'd0 ||
          bus.out_prev !== 8'sd10 || bus.out_cur !== 8'sd20 || bus.out_next !== 8'sd30) begin
        miscompares++;
        $display("FAIL bp_hold_%0d valid=%0b ready=%0b waddr=%0d win=%0d,%0d,%0d exp=1,0,0,10,20,30", c,
                 bus.out_valid, bus.in_ready, bus.mem_waddr, bus.out_prev, bus.out_cur, bus.out_next);
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mem_waddr !== 5'd0) begin
      miscompares++; $display("FAIL bp_release valid=%0b ready=%0b waddr=%0d exp=0,1,0", bus.out_valid, bus.in_ready, bus.mem_waddr);
    end
    $display("backpressure: window held 10 cycles, released");
  endtask

  task automatic test_reset_mid;
    int lat;
    do_reset(2);
    bus.out_ready = 1'b1;
    push(8'sd1);
    wait_valid(8, lat);
    push(8'sd2);
    wait_valid(8, lat);
    push(8'sd3);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.mem_raddr !== 5'd2) begin miscompares++; $display("FAIL mid_rd1_raddr got=%0d exp=2", bus.mem_raddr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.mem_raddr !== 5'd0 || bus.out_prev !== 8'sd0) begin
      miscompares++; $display("FAIL mid_after_reset ready=%0b raddr=%0d prev=%0d exp=1,0,0", bus.in_ready, bus.mem_raddr, bus.out_prev);
    end
    wait_valid(10, lat);
    vectors++;
    if (lat !== -1) begin miscompares++; $display("FAIL mid_no_window got_lat=%0d exp=-1", lat); end
    push(8'sd4);
    wait_valid(8, lat);
    vectors++;
    if (lat !== -1) begin miscompares++; $display("FAIL mid_no_window_4 got_lat=%0d exp=-1", lat); end
    push(8'sd5);
    wait_valid(8, lat);
    vectors++;
    if (lat !== -1) begin miscompares++; $display("FAIL mid_no_window_5 got_lat=%0d exp=-1", lat); end
    push(8'sd6);
    wait_valid(10, lat);
    vectors++;
    if (lat !== 5 || bus.out_prev !== 8'sd4 || bus.out_cur !== 8'sd5 || bus.out_next !== 8'sd6) begin
      miscompares++; $display("FAIL mid_window lat=%0d got=%0d,%0d,%0d exp=5,4,5,6", lat, bus.out_prev, bus.out_cur, bus.out_next);
    end
    $display("reset_mid: window after restart %0d,%0d,%0d", bus.out_prev, bus.out_cur, bus.out_next);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_fill();
    test_zero_extremes();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout sim_time=%0t limit=2000000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
